// File: rtl/servo_pkg.sv
// Shared types and helpers for the servo sequencer block.
// Positions are 8-bit offset binary; widths are in microseconds.
package servo_pkg;

  localparam int POS_W = 8;
  localparam logic [POS_W-1:0] POS_CENTER = 8'd128;

  typedef enum logic [1:0] {
    LIVE = 2'd0,
    PLAY = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  // Pulse width for a position: min_us at 0, scaled span above it (truncating).
  function automatic int unsigned pos_to_width(input logic [POS_W-1:0] pos,
                                               input int unsigned min_us,
                                               input int unsigned span_us);
    int unsigned prod;
    prod = 32'(pos) * span_us;
    return min_us + (prod >> 8);
  endfunction

endpackage

// File: rtl/servo_ch.sv
// One servo channel: slew-limited position, per-frame width register and
// the pulse comparator against the shared microsecond counter.
module servo_ch
  import servo_pkg::*;
#(
  parameter int unsigned US_W      = 16,
  parameter int unsigned MIN_US    = 1000,
  parameter int unsigned SPAN_US   = 1000,
  parameter int unsigned SLEW_STEP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             frame_start_i,
  input  logic [US_W-1:0]  us_cnt_i,
  input  logic [POS_W-1:0] target_i,
  output logic             pwm_o
);

  logic [POS_W-1:0] cur_q, cur_d;
  logic [US_W-1:0]  width_q, width_d;
  logic             pwm_q;
  int               diff_s;

  // Slew step and width recompute, only on frame boundaries so a pulse never changes mid-frame
  always_comb begin
    cur_d   = cur_q;
    width_d = width_q;
    diff_s  = int'(target_i) - int'(cur_q);
    if (frame_start_i) begin
      if ((SLEW_STEP == 0) || ((diff_s <= int'(SLEW_STEP)) && (diff_s >= -int'(SLEW_STEP)))) begin
        cur_d = target_i;
      end else if (diff_s > 0) begin
        cur_d = cur_q + POS_W'(SLEW_STEP);
      end else begin
        cur_d = cur_q - POS_W'(SLEW_STEP);
      end
      width_d = US_W'(pos_to_width(cur_d, MIN_US, SPAN_US));
    end else begin
      cur_d   = cur_q;
      width_d = width_q;
    end
  end

  // Channel state and registered pulse output
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_q   <= POS_CENTER;
      width_q <= US_W'(MIN_US + SPAN_US / 2);
      pwm_q   <= 1'b0;
    end else begin
      cur_q   <= cur_d;
      width_q <= width_d;
      pwm_q   <= en_i & (us_cnt_i < width_q);
    end
  end

  assign pwm_o = pwm_q;

endmodule

// File: rtl/servo_seq_ctrl.sv
// N-channel servo pulse generator: shared frame timer, playback sequencer
// stepping an external ROM, and live/ROM target selection per channel.
module servo_seq_ctrl
  import servo_pkg::*;
#(
  parameter int NUM_CH      = 3,
  parameter int DATA_W      = 16,
  parameter int CLK_HZ      = 50_000_000,
  parameter int PERIOD_US   = 20000,
  parameter int MIN_US      = 1000,
  parameter int SPAN_US     = 1000,
  parameter int SLEW_STEP   = 4,
  parameter int ADDR_W      = 8,
  parameter int HOLD_FRAMES = 25
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       mode,
  input  logic                       start,
  input  logic                       loop,
  input  logic [NUM_CH*DATA_W-1:0]   live_data,
  output logic [ADDR_W-1:0]          rom_addr,
  input  logic [NUM_CH*POS_W-1:0]    rom_data,
  output logic [NUM_CH-1:0]          pwm_out,
  output logic                       frame_tick,
  output logic                       seq_busy
);

  localparam int CYC_PER_US = CLK_HZ / 1_000_000;
  localparam int PSC_W      = (CYC_PER_US > 1) ? $clog2(CYC_PER_US) : 1;
  // Wide enough for both the frame counter and the largest pulse width.
  localparam int US_W       = $clog2(PERIOD_US + MIN_US + SPAN_US + 1);
  localparam int HOLD_W     = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;

  logic [PSC_W-1:0]  psc_q, psc_d;
  logic [US_W-1:0]   us_q, us_d;
  logic              us_tick_s, frame_start_s;
  seq_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              hold_done_s, last_addr_s;
  logic              frame_tick_q, seq_busy_q;

  // Frame timer: microsecond prescaler feeding the frame counter
  always_comb begin
    us_tick_s     = (psc_q == PSC_W'(CYC_PER_US - 1));
    frame_start_s = us_tick_s && (us_q == US_W'(PERIOD_US - 1));
    if (us_tick_s) begin
      psc_d = {PSC_W{1'b0}};
      us_d  = frame_start_s ? {US_W{1'b0}} : us_q + US_W'(1);
    end else begin
      psc_d = psc_q + PSC_W'(1);
      us_d  = us_q;
    end
  end

  // Sequencer next state; mode=0 overrides everything, then start beats frame_start
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    hold_d      = hold_q;
    hold_done_s = (hold_q == HOLD_W'(HOLD_FRAMES - 1));
    last_addr_s = (addr_q == {ADDR_W{1'b1}});
    if (!mode) begin
      state_d = LIVE;
    end else if (start) begin
      state_d = PLAY;
      addr_d  = {ADDR_W{1'b0}};
      hold_d  = {HOLD_W{1'b0}};
    end else begin
      case (state_q)
        PLAY: begin
          if (frame_start_s) begin
            if (!hold_done_s) begin
              hold_d = hold_q + HOLD_W'(1);
            end else begin
              hold_d = {HOLD_W{1'b0}};
              if (!last_addr_s) begin
                addr_d = addr_q + ADDR_W'(1);
              end else if (loop) begin
                addr_d = {ADDR_W{1'b0}};
              end else begin
                state_d = DONE;
              end
            end
          end else begin
            hold_d = hold_q;
          end
        end
        LIVE:    state_d = LIVE;
        DONE:    state_d = DONE;
        default: state_d = LIVE;
      endcase
    end
  end

  // Timer, sequencer and status registers
  always_ff @(posedge clk) begin
    if (rst) begin
      psc_q        <= {PSC_W{1'b0}};
      us_q         <= {US_W{1'b0}};
      state_q      <= LIVE;
      addr_q       <= {ADDR_W{1'b0}};
      hold_q       <= {HOLD_W{1'b0}};
      frame_tick_q <= 1'b0;
      seq_busy_q   <= 1'b0;
    end else begin
      psc_q        <= psc_d;
      us_q         <= us_d;
      state_q      <= state_d;
      addr_q       <= addr_d;
      hold_q       <= hold_d;
      frame_tick_q <= frame_start_s;
      seq_busy_q   <= (state_d == PLAY);
    end
  end

  assign rom_addr   = addr_q;
  assign frame_tick = frame_tick_q;
  assign seq_busy   = seq_busy_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [DATA_W-1:0] live_word_s;
    logic [POS_W-1:0]  live_pos_s;
    logic [POS_W-1:0]  target_s;

    // Two's complement top byte to offset binary: flip the sign bit.
    assign live_word_s = live_data[i*DATA_W +: DATA_W];
    assign live_pos_s  = {~live_word_s[DATA_W-1], live_word_s[DATA_W-2 -: POS_W-1]};
    assign target_s    = (state_q == LIVE) ? live_pos_s : rom_data[i*POS_W +: POS_W];

    if (DATA_W > POS_W) begin : g_low_bits
      logic live_unused_s;
      assign live_unused_s = ^live_word_s[DATA_W-POS_W-1:0];
    end

    servo_ch #(
      .US_W      (US_W),
      .MIN_US    (MIN_US),
      .SPAN_US   (SPAN_US),
      .SLEW_STEP (SLEW_STEP)
    ) u_ch (
      .clk           (clk),
      .rst           (rst),
      .en_i          (en),
      .frame_start_i (frame_start_s),
      .us_cnt_i      (us_q),
      .target_i      (target_s),
      .pwm_o         (pwm_out[i])
    );
  end

endmodule
